regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : FSM state type and default parameters for regfile_mp
// Revision    : 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_ZERO_REG = 1;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_scoreboard : one pending bit per register, set on issue, cleared on write
// Revision      : 1.0
// ---------------------------------------------------------------------------
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [AW-1:0]    set_a,
  input  logic             clr,
  input  logic [AW-1:0]    clr_a,
  input  logic             busy,
  output logic [DEPTH-1:0] bits
);

  localparam logic [DEPTH-1:0] C_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] bits_q;
  logic [DEPTH-1:0] bits_d;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;

  // Set is applied after clear so a same-address issue and write leaves 1.
  always_comb begin
    set_mask = (set && !busy) ? (C_ONE << set_a) : '0;
    clr_mask = (clr && !busy) ? (C_ONE << clr_a) : '0;
    if (ZERO_REG != 0) begin
      set_mask[0] = 1'b0;
    end
    bits_d = (bits_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign bits = bits_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_mp : multi-read-port register file with clear FSM and scoreboard
// Revision   : 1.0
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   iss,
  input  logic [AW-1:0]          ia,
  output logic [NREAD-1:0]       pend,
  output logic                   busy
);

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] bits;

  logic             run_we;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  assign run_we = (state_q == RUN) && we && !((ZERO_REG != 0) && (wa == '0));

  // The clear sequence and normal writes share the single storage write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = '0;
    if (!reset) begin
      if (state_q == CLEAR) begin
        wr_en = 1'b1;
      end else if (run_we) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk   (clk),
    .reset (reset),
    .set   (iss),
    .set_a (ia),
    .clr   (we),
    .clr_a (wa),
    .busy  (busy_q),
    .bits  (bits)
  );

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] val;

      assign addr = ra[i*AW +: AW];

      always_comb begin
        val = rf_q[addr];
        if ((ZERO_REG != 0) && (addr == '0)) begin
          val = '0;
        end
        if ((BYPASS != 0) && run_we && (wa == addr)) begin
          val = wd;
        end
        if (busy_q) begin
          val = '0;
        end
      end

      assign rd[i*WIDTH +: WIDTH] = val;
      assign pend[i]              = busy_q ? 1'b0 : bits[addr];
    end
  endgenerate

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_mp : directed checks on a default instance and a 16x32, 4-port,
//                 no-bypass instance; revision 1.0
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;

  logic         a_we, a_iss, a_busy;
  logic [4:0]   a_wa, a_ia;
  logic [31:0]  a_wd;
  logic [9:0]   a_ra;
  logic [63:0]  a_rd;
  logic [1:0]   a_pend;

  logic         b_we, b_iss, b_busy;
  logic [3:0]   b_wa, b_ia;
  logic [31:0]  b_wd;
  logic [15:0]  b_ra;
  logic [127:0] b_rd;
  logic [3:0]   b_pend;

  int checks = 0;
  int errors = 0;
  int na, nb, n;
  logic [31:0] mdl [16];
  logic [3:0]  ad  [4];

  regfile_mp u_a (
    .clk(clk), .reset(reset), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra),
    .rd(a_rd), .iss(a_iss), .ia(a_ia), .pend(a_pend), .busy(a_busy)
  );

  regfile_mp #(
    .WIDTH(32), .DEPTH(16), .NREAD(4), .BYPASS(0), .ZERO_REG(1)
  ) u_b (
    .clk(clk), .reset(reset), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra),
    .rd(b_rd), .iss(b_iss), .ia(b_ia), .pend(b_pend), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_we = 0; a_iss = 0; a_wa = 0; a_ia = 0; a_wd = 0; a_ra = 0;
    b_we = 0; b_iss = 0; b_wa = 0; b_ia = 0; b_wd = 0; b_ra = 0;
    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;

    // Reset edge, then count busy cycles through the clear sequence
    tick;
    chk("reset_busy_a", 32'(a_busy), 32'd1);
    chk("reset_busy_b", 32'(b_busy), 32'd1);
    chk("clear_pend_a", 32'(a_pend), 32'd0);
    chk("clear_rd_a",   a_rd[31:0],  32'd0);
    reset = 1'b0;
    na = 1; nb = 1;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (a_busy) na++;
      if (b_busy) nb++;
      if (!a_busy && !b_busy) break;
    end
    chk("busy_len_a", 32'(na), 32'd32);
    chk("busy_len_b", 32'(nb), 32'd16);

    a_ra = {5'd31, 5'd3};
    #1;
    chk("run_rd0_zero", a_rd[31:0],  32'd0);
    chk("run_rd1_zero", a_rd[63:32], 32'd0);

    // Write 5 with same-cycle read: bypass on a, not on b
    a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF; a_ra[4:0] = 5;
    b_we = 1; b_wa = 5; b_wd = 32'hDEADBEEF; b_ra[3:0] = 5;
    #1;
    chk("bypass_a",    a_rd[31:0], 32'hDEADBEEF);
    chk("no_bypass_b", b_rd[31:0], 32'd0);
    tick;
    a_we = 0; b_we = 0;
    #1;
    chk("after_wr_a", a_rd[31:0], 32'hDEADBEEF);
    chk("after_wr_b", b_rd[31:0], 32'hDEADBEEF);

    // Register 0 stays zero
    a_we = 1; a_wa = 0; a_wd = 32'h12345678; a_ra[4:0] = 0;
    #1;
    chk("zero_bypass", a_rd[31:0], 32'd0);
    tick;
    a_we = 0;
    #1;
    chk("zero_read", a_rd[31:0], 32'd0);

    a_iss = 1; a_ia = 0; a_ra[9:5] = 0;
    tick;
    a_iss = 0;
    #1;
    chk("pend_zero", 32'(a_pend[1]), 32'd0);

    // Scoreboard set / clear / collision
    a_iss = 1; a_ia = 7; a_ra[9:5] = 7;
    #1;
    chk("pend_not_bypassed", 32'(a_pend[1]), 32'd0);
    tick;
    a_iss = 0;
    #1;
    chk("pend_set", 32'(a_pend[1]), 32'd1);
    a_we = 1; a_wa = 7; a_wd = 32'h77;
    #1;
    chk("pend_hold_on_wr", 32'(a_pend[1]), 32'd1);
    chk("bypass_rd1",      a_rd[63:32],    32'h77);
    tick;
    a_we = 0;
    #1;
    chk("pend_clr", 32'(a_pend[1]), 32'd0);

    a_iss = 1; a_ia = 9; a_we = 1; a_wa = 9; a_wd = 32'h99;
    tick;
    a_iss = 0; a_we = 0; a_ra = {5'd9, 5'd9};
    #1;
    chk("pend_set_wins", 32'(a_pend), 32'd3);
    chk("rd0_9", a_rd[31:0],  32'h99);
    chk("rd1_9", a_rd[63:32], 32'h99);
    a_ra = {5'd5, 5'd5};
    #1;
    chk("same_addr_rd0", a_rd[31:0],  32'hDEADBEEF);
    chk("same_addr_rd1", a_rd[63:32], 32'hDEADBEEF);

    // Reset in RUN with a write/issue pending, then re-reset at clear cycle 10
    a_iss = 1; a_ia = 12; a_we = 1; a_wa = 12; a_wd = 32'h1212;
    reset = 1'b1;
    tick;
    reset = 1'b0; a_iss = 0; a_we = 0;
    for (int c = 0; c < 10; c++) tick;
    chk("busy_mid_clear", 32'(a_busy), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n = 1;
    for (int c = 0; c < 100 && a_busy; c++) begin
      a_we = (c == 20); a_wa = 3; a_wd = 32'hCAFEF00D;
      a_iss = (c == 20); a_ia = 4;
      tick;
      if (a_busy) n++;
    end
    a_we = 0; a_iss = 0;
    chk("busy_len_restart", 32'(n), 32'd32);
    a_ra = {5'd4, 5'd3};
    #1;
    chk("clear_ignores_we",  a_rd[31:0],     32'd0);
    chk("clear_ignores_iss", 32'(a_pend[1]), 32'd0);
    a_ra = {5'd12, 5'd5};
    #1;
    chk("cleared_reg5", a_rd[31:0], 32'd0);
    chk("pend12_reset", 32'(a_pend), 32'd0);

    // Random writes to b, then distinct and identical multi-port reads
    for (int k = 0; k < 40; k++) begin
      b_we = 1; b_wa = 4'($urandom_range(0, 15)); b_wd = $urandom;
      tick;
      if (b_wa != 4'd0) mdl[b_wa] = b_wd;
    end
    b_we = 0;
    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < 4; j++) begin
        ad[j] = (p < 3) ? 4'(4 * j + p) : 4'(3 * p);
        b_ra[j*4 +: 4] = ad[j];
      end
      #1;
      for (int j = 0; j < 4; j++) begin
        chk("b_port_read", b_rd[j*32 +: 32], mdl[ad[j]]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
